arbitro_memoria_dados: RTL and testbench
========================================

// Module: arbitro_memoria_dados
// PURPOSE
//   Arbitrates and sequences the single-port 64x16 data memory (memoram_dados) between two requesters:
//   port 0 = processor datapath (ADDR/DOUT/W_D path), port 1 = FPGA debug/loader port.
//   Round-robin fairness, one access in flight at a time. Hides synchronous-RAM read latency behind
//   a grant/rvalid handshake. Sits between the requesters and the memory's address/data/wren/q pins.
// PARAMETERS
//   ADDR_W  6   memory address width (64 words)
//   DATA_W  16  memory data width
//   RD_LAT  1   cycles from the address-capture edge to valid mem_q; legal range 1..4
// PORTS
//   Clock        in   1       single clock; all state updates on rising edge
//   Resetn       in   1       asynchronous reset, active-high (1 = reset), despite the name
//   req0_valid   in   1       port 0 request; held high until req0_grant
//   req0_we      in   1       port 0: 1 = write, 0 = read
//   req0_addr    in   ADDR_W  port 0 address
//   req0_wdata   in   DATA_W  port 0 write data
//   req0_grant   out  1       1-cycle pulse: port 0 request accepted this cycle
//   req0_rvalid  out  1       1-cycle pulse: req0_rdata valid
//   req0_rdata   out  DATA_W  port 0 read data
//   req1_*       same as req0_* for port 1
//   mem_address  out  ADDR_W  to memory address
//   mem_data     out  DATA_W  to memory data
//   mem_wren     out  1       to memory write enable
//   mem_q        in   DATA_W  memory read data
//   busy         out  1       1 when state != IDLE
// BEHAVIOUR
//   Reset: state = IDLE; mem_address = 0, mem_data = 0, mem_wren = 0, grants = 0, rvalids = 0,
//     rdata = 0, busy = 0, rr pointer = 1 (port 0 wins first contention).
//   FSM: IDLE -> ISSUE -> (write) IDLE | (read) WAIT -> IDLE.
//   IDLE: if exactly one valid, that port wins; if both valid, the port != rr pointer wins.
//     reqN_grant = 1 combinationally in this cycle; on the edge, latch addr/we/wdata, set rr = winner,
//     and go to ISSUE. Requester may drop valid or change fields after the granted cycle.
//   ISSUE (1 cycle): mem_address = latched addr, mem_data = latched wdata,
//     mem_wren = latched we (only asserted in ISSUE). Write -> IDLE. Read -> WAIT with cnt = RD_LAT-1.
//   WAIT: lasts RD_LAT cycles (cnt down to 0). In the last WAIT cycle, mem_q is registered into the
//     winner's rdata, then -> IDLE. The winner's rvalid pulses in the following cycle, which coincides
//     with IDLE, so a new grant can occur in the same cycle.
//   Latency (grant = cycle 0): write lands on the edge ending cycle 1, next grant possible in cycle 2.
//     Read: rvalid in cycle 2+RD_LAT, next grant possible in cycle 2+RD_LAT.
//   mem_address and mem_data hold their last latched value outside ISSUE; mem_wren = 0 outside ISSUE.
//   reqN_rdata holds its value until that port's next read completes.
//   No grant outside IDLE. valid raised while busy waits, with no loss.
//   Single requester: served back-to-back; rr only matters under contention.
//   Reset asserted mid-operation: immediate return to reset values; mem_wren drops asynchronously,
//     the pending read is discarded (no rvalid), and the requester must reissue.
//   Address/data are passed unmodified (no wrap arithmetic). RD_LAT counter is 2 bits.
// TESTING
//   1. Reset, port0 write addr 5 = 0x1234 -> grant0 at c0, mem_wren = 1 & mem_address = 5 at c1 only,
//      busy c1, idle c2.
//   2. Port0 read addr 5 after test 1 (RD_LAT=1) -> grant0 c0, rvalid0 c3 with rdata0 = 0x1234,
//      rvalid1 never.
//   3. Both valid from reset (p0 read 3, p1 read 7) -> grant0 first, then grant1 in the cycle p0's rvalid
//      pulses; rdata routed to the correct port.
//   4. Both held valid continuously for 8 grants -> grants alternate 0,1,0,1...; neither port is starved.
//   5. Assert Resetn during WAIT of a port1 read -> mem_wren = 0, busy = 0 immediately, no rvalid1;
//      the next request after release is served normally.
//   6. RD_LAT=3 build, port1 read -> rvalid1 at c5, data equals memory contents, mem_wren stays 0 throughout.

Source files
------------

// File: rtl/arbitro_memoria_dados_if.sv
// Bus bundle between the two requesters, the data-memory arbiter and the 64x16 memory pins.
interface arbitro_memoria_dados_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_grant;
    logic              req0_rvalid;
    logic [DATA_W-1:0] req0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_grant;
    logic              req1_rvalid;
    logic [DATA_W-1:0] req1_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;
    logic              busy;

    // Requester/memory side: drives requests and memory read data.
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_grant, req0_rvalid, req0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_grant, req1_rvalid, req1_rdata,
        input  mem_address, mem_data, mem_wren, busy,
        output mem_q
    );

    // Arbiter side.
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_grant, req0_rvalid, req0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_grant, req1_rvalid, req1_rdata,
        output mem_address, mem_data, mem_wren, busy,
        input  mem_q
    );
endinterface

// File: rtl/arbitro_memoria_dados.sv
// Round-robin arbiter/sequencer for the single-port data memory: one access in flight,
// synchronous read latency hidden behind a grant / rvalid handshake.
module arbitro_memoria_dados #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input logic Clock,
    input logic Resetn,
    arbitro_memoria_dados_if.slave bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    logic [1:0]        state;
    logic [1:0]        cnt;
    logic              rr;
    logic              lat_port;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              grant0;
    logic              grant1;

    // rr holds the last winner; under contention the other port is served.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !Resetn) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant0 = rr;
                grant1 = !rr;
            end else begin
                grant0 = bus.req0_valid;
                grant1 = bus.req1_valid;
            end
        end
    end

    assign bus.req0_grant  = grant0;
    assign bus.req1_grant  = grant1;
    assign bus.req0_rvalid = rvalid0;
    assign bus.req1_rvalid = rvalid1;
    assign bus.req0_rdata  = rdata0;
    assign bus.req1_rdata  = rdata1;
    assign bus.mem_address = lat_addr;
    assign bus.mem_data    = lat_wdata;
    assign bus.mem_wren    = (state == ISSUE) && lat_we;
    assign bus.busy        = (state != IDLE);

    always_ff @(posedge Clock or posedge Resetn) begin
        if (Resetn) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            rr        <= 1'b1;
            lat_port  <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rvalid0   <= 1'b0;
            rvalid1   <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        rr        <= grant1;
                        lat_port  <= grant1;
                        lat_we    <= grant1 ? bus.req1_we    : bus.req0_we;
                        lat_addr  <= grant1 ? bus.req1_addr  : bus.req0_addr;
                        lat_wdata <= grant1 ? bus.req1_wdata : bus.req0_wdata;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (lat_we) begin
                        state <= IDLE;
                    end else begin
                        cnt   <= CNT_INIT;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // Last WAIT cycle: mem_q is valid now; rvalid shows up in the next (IDLE) cycle.
                    if (cnt == 2'd0) begin
                        if (lat_port) begin
                            rdata1  <= bus.mem_q;
                            rvalid1 <= 1'b1;
                        end else begin
                            rdata0  <= bus.mem_q;
                            rvalid0 <= 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Bench for the data-memory arbiter: RD_LAT=1 instance tracked by a cycle-level transaction model,
// RD_LAT=3 instance checked with hand-computed expectations.
module tb_arbitro_memoria_dados;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 16;
    localparam int M_LAT  = 1;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    arbitro_memoria_dados_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifa ();
    arbitro_memoria_dados_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifb ();

    arbitro_memoria_dados #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut_a (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (ifa)
    );

    arbitro_memoria_dados #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3)) dut_b (
        .Clock (Clock),
        .Resetn(Resetn),
        .bus   (ifb)
    );

    function automatic logic [15:0] init_val(input int i);
        return 16'hA500 + 16'(i);
    endfunction

    // Synchronous RAMs: A answers one cycle after the address edge, B three cycles after.
    bit          ram_ready = 1'b0;
    logic [15:0] ram_a [64];
    logic [15:0] ram_b [64];
    logic [15:0] q_a;
    logic [15:0] q_b [3];

    always @(posedge Clock) begin
        if (!ram_ready) begin
            for (int i = 0; i < 64; i++) begin
                ram_a[i] <= init_val(i);
                ram_b[i] <= init_val(i);
            end
            ram_ready <= 1'b1;
        end else begin
            if (ifa.mem_wren) ram_a[ifa.mem_address] <= ifa.mem_data;
            if (ifb.mem_wren) ram_b[ifb.mem_address] <= ifb.mem_data;
        end
        q_a    <= ram_a[ifa.mem_address];
        q_b[0] <= ram_b[ifb.mem_address];
        q_b[1] <= q_b[0];
        q_b[2] <= q_b[1];
    end

    assign ifa.mem_q = q_a;
    assign ifb.mem_q = q_b[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Transaction model of instance A: a grant at cycle g puts the access on the memory pins at g+1;
    // a write frees the arbiter at g+2, a read returns data and frees it at g+2+M_LAT.
    logic [15:0] model_mem [64];
    int          m_free, m_iss, m_rv;
    bit          m_last, m_iss_we, m_rv_port;
    logic [5:0]  m_addr, m_iss_addr;
    logic [15:0] m_data, m_iss_data, m_rv_data;
    logic [15:0] m_rd [2];
    bit          e_g0, e_g1, e_rv0, e_rv1, e_wren, e_busy, w, v0, v1;

    initial begin
        for (int i = 0; i < 64; i++) model_mem[i] = init_val(i);
        m_free = 0; m_iss = -1; m_rv = -1; m_last = 1'b1;
        m_addr = '0; m_data = '0; m_rd[0] = '0; m_rd[1] = '0;
        m_iss_we = 1'b0; m_rv_port = 1'b0; m_iss_addr = '0; m_iss_data = '0; m_rv_data = '0;
        forever begin
            @(negedge Clock);
            e_g0 = 0; e_g1 = 0; e_rv0 = 0; e_rv1 = 0; e_wren = 0; e_busy = 0;
            if (Resetn) begin
                m_free = 0; m_iss = -1; m_rv = -1; m_last = 1'b1;
                m_addr = '0; m_data = '0; m_rd[0] = '0; m_rd[1] = '0;
            end else begin
                if (cyc == m_iss) begin
                    m_addr = m_iss_addr;
                    m_data = m_iss_data;
                    e_wren = m_iss_we;
                    if (m_iss_we) model_mem[m_iss_addr] = m_iss_data;
                end
                if (cyc == m_rv) begin
                    m_rd[m_rv_port] = m_rv_data;
                    e_rv0 = !m_rv_port;
                    e_rv1 = m_rv_port;
                end
                e_busy = (cyc < m_free);
                v0 = ifa.req0_valid;
                v1 = ifa.req1_valid;
                if (!e_busy && (v0 || v1)) begin
                    w      = (v0 && v1) ? !m_last : v1;
                    e_g0   = !w;
                    e_g1   = w;
                    m_last = w;
                    m_iss      = cyc + 1;
                    m_iss_we   = w ? ifa.req1_we    : ifa.req0_we;
                    m_iss_addr = w ? ifa.req1_addr  : ifa.req0_addr;
                    m_iss_data = w ? ifa.req1_wdata : ifa.req0_wdata;
                    if (m_iss_we) begin
                        m_free = cyc + 2;
                    end else begin
                        m_rv      = cyc + 2 + M_LAT;
                        m_rv_port = w;
                        m_rv_data = model_mem[m_iss_addr];
                        m_free    = cyc + 2 + M_LAT;
                    end
                end
            end
            chk("m_grant0",  32'(ifa.req0_grant),  32'(e_g0));
            chk("m_grant1",  32'(ifa.req1_grant),  32'(e_g1));
            chk("m_rvalid0", 32'(ifa.req0_rvalid), 32'(e_rv0));
            chk("m_rvalid1", 32'(ifa.req1_rvalid), 32'(e_rv1));
            chk("m_rdata0",  32'(ifa.req0_rdata),  32'(m_rd[0]));
            chk("m_rdata1",  32'(ifa.req1_rdata),  32'(m_rd[1]));
            chk("m_busy",    32'(ifa.busy),        32'(e_busy));
            chk("m_wren",    32'(ifa.mem_wren),    32'(e_wren));
            chk("m_address", 32'(ifa.mem_address), 32'(m_addr));
            chk("m_data",    32'(ifa.mem_data),    32'(m_data));
        end
    end

    task automatic set_req(input int p, input bit v, input bit we, input logic [5:0] a, input logic [15:0] d);
        case (p)
            0: begin ifa.req0_we = we; ifa.req0_addr = a; ifa.req0_wdata = d; ifa.req0_valid = v; end
            1: begin ifa.req1_we = we; ifa.req1_addr = a; ifa.req1_wdata = d; ifa.req1_valid = v; end
            2: begin ifb.req0_we = we; ifb.req0_addr = a; ifb.req0_wdata = d; ifb.req0_valid = v; end
            default: begin ifb.req1_we = we; ifb.req1_addr = a; ifb.req1_wdata = d; ifb.req1_valid = v; end
        endcase
    endtask

    function automatic bit grant_of(input int p);
        case (p)
            0:       return ifa.req0_grant;
            1:       return ifa.req1_grant;
            2:       return ifb.req0_grant;
            default: return ifb.req1_grant;
        endcase
    endfunction

    // Holds valid until granted; returns at 1 time unit into the cycle after the grant.
    task automatic do_req(input int p, input bit we, input logic [5:0] a, input logic [15:0] d,
                          output int gcyc);
        set_req(p, 1'b1, we, a, d);
        gcyc = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            if (grant_of(p)) begin
                gcyc = cyc;
                break;
            end
        end
        if (gcyc < 0) chk("grant_timeout", 32'd0, 32'd1);
        @(posedge Clock);
        #1;
        set_req(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic pulse_reset();
        Resetn = 1'b1;
        @(posedge Clock);
        #1;
        Resetn = 1'b0;
    endtask

    initial begin
        int g, g0, g1, k;
        int seq [8];
        for (int p = 0; p < 4; p++) set_req(p, 1'b0, 1'b0, '0, '0);
        #1 Resetn = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_grant0",  32'(ifa.req0_grant),  32'd0);
        chk("rst_rvalid0", 32'(ifa.req0_rvalid), 32'd0);
        chk("rst_rdata1",  32'(ifa.req1_rdata),  32'd0);
        chk("rst_busy",    32'(ifa.busy),        32'd0);
        chk("rst_wren",    32'(ifa.mem_wren),    32'd0);
        chk("rst_address", 32'(ifa.mem_address), 32'd0);
        chk("rst_busy_b",  32'(ifb.busy),        32'd0);
        Resetn = 1'b0;

        // 1: write 0x1234 to address 5
        do_req(0, 1'b1, 6'd5, 16'h1234, g);
        chk("t1_wren_c1",  32'(ifa.mem_wren),    32'd1);
        chk("t1_addr_c1",  32'(ifa.mem_address), 32'd5);
        chk("t1_data_c1",  32'(ifa.mem_data),    32'h1234);
        chk("t1_busy_c1",  32'(ifa.busy),        32'd1);
        @(posedge Clock); #1;
        chk("t1_wren_c2",  32'(ifa.mem_wren),    32'd0);
        chk("t1_busy_c2",  32'(ifa.busy),        32'd0);

        // 2: read it back
        do_req(0, 1'b0, 6'd5, 16'h0000, g);
        @(posedge Clock); #1;
        chk("t2_rvalid0_c2", 32'(ifa.req0_rvalid), 32'd0);
        @(posedge Clock); #1;
        chk("t2_latency",    32'(cyc - g),         32'd3);
        chk("t2_rvalid0_c3", 32'(ifa.req0_rvalid), 32'd1);
        chk("t2_rdata0",     32'(ifa.req0_rdata),  32'h1234);
        chk("t2_rvalid1",    32'(ifa.req1_rvalid), 32'd0);

        // 3: contention from reset, port 0 first
        pulse_reset();
        fork
            do_req(0, 1'b0, 6'd3, 16'h0000, g0);
            do_req(1, 1'b0, 6'd7, 16'h0000, g1);
        join
        repeat (4) @(posedge Clock);
        #1;
        chk("t3_grant_gap", 32'(g1 - g0),         32'd3);
        chk("t3_rdata0",    32'(ifa.req0_rdata),  32'hA503);
        chk("t3_rdata1",    32'(ifa.req1_rdata),  32'hA507);

        // 4: both held valid for 8 grants
        pulse_reset();
        set_req(0, 1'b1, 1'b1, 6'd40, 16'h4000);
        set_req(1, 1'b1, 1'b1, 6'd41, 16'h4100);
        k = 0;
        for (int i = 0; i < 100 && k < 8; i++) begin
            @(negedge Clock);
            if (ifa.req0_grant)      begin seq[k] = 0; k++; end
            else if (ifa.req1_grant) begin seq[k] = 1; k++; end
        end
        @(posedge Clock); #1;
        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        chk("t4_grant_count", 32'(k), 32'd8);
        for (int i = 0; i < k; i++) chk("t4_order", 32'(seq[i]), 32'(i % 2));

        // 5: reset during a write ISSUE, then during a read WAIT
        repeat (3) @(posedge Clock);
        #1;
        do_req(0, 1'b1, 6'd9, 16'hDEAD, g);
        chk("t5_wren_issue", 32'(ifa.mem_wren), 32'd1);
        #1 Resetn = 1'b1;
        #1;
        chk("t5_wren_async", 32'(ifa.mem_wren), 32'd0);
        chk("t5_busy_async", 32'(ifa.busy),     32'd0);
        @(posedge Clock); #1;
        Resetn = 1'b0;
        do_req(1, 1'b0, 6'd9, 16'h0000, g);
        @(posedge Clock); #1;
        chk("t5_busy_wait",  32'(ifa.busy),     32'd1);
        #1 Resetn = 1'b1;
        #1;
        chk("t5_busy_rst",   32'(ifa.busy),     32'd0);
        chk("t5_wren_rst",   32'(ifa.mem_wren), 32'd0);
        @(posedge Clock); #1;
        Resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge Clock); #1;
            chk("t5_no_rvalid1", 32'(ifa.req1_rvalid), 32'd0);
        end
        do_req(1, 1'b0, 6'd9, 16'h0000, g);
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        chk("t5_reissue_rvalid1", 32'(ifa.req1_rvalid), 32'd1);
        chk("t5_reissue_rdata1",  32'(ifa.req1_rdata),  32'hA509);

        // 6: RD_LAT=3 instance, port 1 read of address 20
        do_req(3, 1'b0, 6'd20, 16'h0000, g);
        chk("t6_wren_c1", 32'(ifb.mem_wren), 32'd0);
        for (int c = 2; c <= 5; c++) begin
            @(posedge Clock); #1;
            chk("t6_wren",    32'(ifb.mem_wren),    32'd0);
            chk("t6_rvalid1", 32'(ifb.req1_rvalid), 32'(c == 5));
        end
        chk("t6_latency", 32'(cyc - g),          32'd5);
        chk("t6_rdata1",  32'(ifb.req1_rdata),   32'hA514);
        chk("t6_rvalid0", 32'(ifb.req0_rvalid),  32'd0);

        @(posedge Clock); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "time limit");
    end

endmodule
